// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and widths for the dot-product sequencer and its environment.
package dotp_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned PROD_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_ARM,
      S_WAIT,
      S_OUT
   } state_t;

   // Smallest accumulator that cannot overflow over vec_len full-scale products.
   function automatic int unsigned min_acc_w(input int unsigned vec_len);
      return PROD_W + $clog2(vec_len);
   endfunction

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Operand input, multiplier-side and sum-output signals of the sequencer, grouped as one bundle.
interface dot_product_sequencer_if #(
   parameter int unsigned ACC_W = 12
);
   import dotp_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_a;
   logic [OP_W-1:0]   in_b;
   logic              mul_start;
   logic [OP_W-1:0]   mul_multiplier;
   logic [OP_W-1:0]   mul_multiplicand;
   logic [PROD_W-1:0] mul_product;
   logic              mul_done;
   logic              sum_valid;
   logic [ACC_W-1:0]  sum;
   logic              sum_ready;

   modport slave (
      input  in_valid, in_a, in_b, mul_product, mul_done, sum_ready,
      output in_ready, mul_start, mul_multiplier, mul_multiplicand, sum_valid, sum
   );

   modport master (
      output in_valid, in_a, in_b, mul_product, mul_done, sum_ready,
      input  in_ready, mul_start, mul_multiplier, mul_multiplicand, sum_valid, sum
   );

endinterface

// File: rtl/dot_product_sequencer_sync_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/multiplier4x4.sv
// Shift-add 4x4 multiplier: one partial product per cycle, one-cycle process_done with the result.
module multiplier4x4 (
   input  logic       CLK,
   input  logic       RESETn,
   input  logic       process_start,
   input  logic [3:0] multiplier,
   input  logic [3:0] multiplicand,
   output logic [7:0] product,
   output logic       process_done
);
   logic       busy;
   logic [1:0] step;
   logic [7:0] mcand;
   logic [3:0] mplier;

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         busy         <= 1'b0;
         step         <= '0;
         mcand        <= '0;
         mplier       <= '0;
         product      <= '0;
         process_done <= 1'b0;
      end else begin
         process_done <= 1'b0;
         if (process_start) begin
            busy    <= 1'b1;
            step    <= '0;
            mcand   <= {4'b0000, multiplicand};
            mplier  <= multiplier;
            product <= '0;
         end else if (busy) begin
            if (mplier[0]) begin
               product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + 2'd1;
            if (step == 2'd3) begin
               busy         <= 1'b0;
               process_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dot_product_sequencer.sv
// Feeds queued operand pairs through an external multiplier and accumulates a fixed-length dot product.
module dot_product_sequencer
   import dotp_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned VEC_LEN = 4,
   parameter int unsigned ACC_W   = 12
) (
   input  logic                    CLK,
   input  logic                    RESET,
   dot_product_sequencer_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(VEC_LEN) + 1;

   if (ACC_W < min_acc_w(VEC_LEN)) begin : g_acc_w_check
      $error("ACC_W too narrow for VEC_LEN");
   end

   state_t              state;
   logic [2*OP_W-1:0]   head;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic [OP_W-1:0]     op_a;
   logic [OP_W-1:0]     op_b;
   logic [ACC_W-1:0]    acc;
   logic [CNT_W-1:0]    cnt;

   assign push = bus.in_valid && !full;
   assign pop  = (state == S_IDLE) && !empty;

   sync_fifo #(
      .WIDTH (2*OP_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RESET),
      .push  (push),
      .din   ({bus.in_a, bus.in_b}),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // ARM sits between the start pulse and WAIT so a done left high by the
   // previous product is never mistaken for the new one.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= S_IDLE;
         op_a  <= '0;
         op_b  <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  op_a  <= head[2*OP_W-1:OP_W];
                  op_b  <= head[OP_W-1:0];
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_ARM;
            S_ARM:   state <= S_WAIT;
            S_WAIT: begin
               if (bus.mul_done) begin
                  acc   <= acc + ACC_W'(bus.mul_product);
                  cnt   <= cnt + 1'b1;
                  state <= (cnt == CNT_W'(VEC_LEN - 1)) ? S_OUT : S_IDLE;
               end
            end
            S_OUT: begin
               if (bus.sum_ready) begin
                  acc   <= '0;
                  cnt   <= '0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready         = !full;
   assign bus.mul_start        = (state == S_ISSUE);
   assign bus.mul_multiplier   = op_a;
   assign bus.mul_multiplicand = op_b;
   assign bus.sum_valid        = (state == S_OUT);
   assign bus.sum              = (state == S_OUT) ? acc : '0;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer driving a real multiplier4x4, with pair and sum scoreboards.
module tb_dot_product_sequencer;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   dot_product_sequencer_if #(.ACC_W(12)) bus ();

   logic       real_done;
   logic       stretch = 1'b0;
   logic [2:0] done_hist;

   dot_product_sequencer #(
      .DEPTH   (4),
      .VEC_LEN (4),
      .ACC_W   (12)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   multiplier4x4 u_mul (
      .CLK           (CLK),
      .RESETn        (~RESET),
      .process_start (bus.mul_start),
      .multiplier    (bus.mul_multiplier),
      .multiplicand  (bus.mul_multiplicand),
      .product       (bus.mul_product),
      .process_done  (real_done)
   );

   // Optional stretch keeps done high for three extra cycles, across the next start.
   always @(posedge CLK) done_hist <= RESET ? 3'b000 : {done_hist[1:0], real_done};
   assign bus.mul_done = real_done | (stretch & (|done_hist));

   logic [7:0]  pair_q[$];
   int unsigned sum_q[$];
   int unsigned vacc = 0;
   int          vn = 0;
   int          starts = 0;
   int          sums_seen = 0;
   int          dones = 0;
   logic        busy_chk = 1'b0;
   logic [7:0]  held_ops = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      if (RESET) begin
         pair_q.delete();
         vacc     = 0;
         vn       = 0;
         busy_chk = 1'b0;
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            pair_q.push_back({bus.in_a, bus.in_b});
            vacc += int'(bus.in_a) * int'(bus.in_b);
            vn++;
            if (vn == 4) begin
               sum_q.push_back(vacc);
               vacc = 0;
               vn   = 0;
            end
         end
         if (real_done) dones++;
         if (busy_chk) begin
            chk("op_hold", {24'd0, bus.mul_multiplier, bus.mul_multiplicand}, {24'd0, held_ops});
            if (bus.mul_done) busy_chk = 1'b0;
         end
         if (bus.mul_start) begin
            starts++;
            chk("start_pair_expected", {31'd0, pair_q.size() != 0}, 32'd1);
            if (pair_q.size() != 0) begin
               chk("start_ops", {24'd0, bus.mul_multiplier, bus.mul_multiplicand}, {24'd0, pair_q.pop_front()});
            end
            busy_chk = 1'b1;
            held_ops = {bus.mul_multiplier, bus.mul_multiplicand};
         end
         if (bus.sum_valid && bus.sum_ready) begin
            sums_seen++;
            chk("sum_expected", {31'd0, sum_q.size() != 0}, 32'd1);
            if (sum_q.size() != 0) begin
               chk("sum", {20'd0, bus.sum}, sum_q.pop_front());
            end
         end
      end
   end

   task automatic push(input logic [3:0] a, input logic [3:0] b);
      int k = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      while (!bus.in_ready && k < 500) begin
         tick();
         k++;
      end
      chk("push_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_sums(input int target, input string tag);
      int k = 0;
      while (sums_seen < target && k < 1000) begin
         tick();
         k++;
      end
      chk(tag, {31'd0, sums_seen >= target}, 32'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"},  {31'd0, bus.in_ready},         32'd1);
      chk({tag, "_mul_start"}, {31'd0, bus.mul_start},        32'd0);
      chk({tag, "_mplier"},    {28'd0, bus.mul_multiplier},   32'd0);
      chk({tag, "_mcand"},     {28'd0, bus.mul_multiplicand}, 32'd0);
      chk({tag, "_sum_valid"}, {31'd0, bus.sum_valid},        32'd0);
      chk({tag, "_sum"},       {20'd0, bus.sum},              32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.sum_ready = 1'b1;
      RESET = 1'b1;
      repeat (2) tick();
      chk_reset("rst0");
      RESET = 1'b0;
      tick();

      // Vector 1 back-to-back with start timing checks.
      bus.in_valid = 1'b1; bus.in_a = 4'd4; bus.in_b = 4'd9;
      tick();
      chk("t_start_low", {31'd0, bus.mul_start}, 32'd0);
      bus.in_a = 4'd1; bus.in_b = 4'd1;
      tick();
      chk("t_start_high", {31'd0, bus.mul_start}, 32'd1);
      chk("t_mplier", {28'd0, bus.mul_multiplier}, 32'd4);
      chk("t_mcand", {28'd0, bus.mul_multiplicand}, 32'd9);
      bus.in_a = 4'd15; bus.in_b = 4'd15;
      tick();
      chk("t_start_pulse", {31'd0, bus.mul_start}, 32'd0);
      bus.in_a = 4'd0; bus.in_b = 4'd7;
      tick();
      bus.in_valid = 1'b0;
      wait_sums(1, "vec1_timeout");
      chk("vec1_out_1cycle", {31'd0, bus.sum_valid}, 32'd0);
      chk("vec1_starts", starts, 32'd4);

      // All-max vector.
      repeat (4) push(4'd15, 4'd15);
      wait_sums(2, "max_timeout");
      chk("max_out_1cycle", {31'd0, bus.sum_valid}, 32'd0);

      // Sum backpressure while the FIFO fills.
      bus.sum_ready = 1'b0;
      push(4'd4, 4'd9); push(4'd1, 4'd1); push(4'd15, 4'd15); push(4'd0, 4'd7);
      k = 0;
      while (!bus.sum_valid && k < 500) begin tick(); k++; end
      chk("bp_out_reached", {31'd0, bus.sum_valid}, 32'd1);
      push(4'd2, 4'd5); push(4'd3, 4'd3); push(4'd7, 4'd1); push(4'd6, 4'd6);
      chk("bp_hold_sum", {20'd0, bus.sum}, 32'h106);
      chk("bp_hold_valid", {31'd0, bus.sum_valid}, 32'd1);
      bus.in_valid = 1'b1; bus.in_a = 4'd9; bus.in_b = 4'd9;
      chk("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      chk("bp_full_refused", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold_sum2", {20'd0, bus.sum}, 32'h106);
      bus.sum_ready = 1'b1;
      push(4'd9, 4'd9); push(4'd8, 4'd2); push(4'd5, 4'd5); push(4'd1, 4'd14);
      wait_sums(5, "bp_drain_timeout");

      // Reset while waiting on the third product.
      k = dones;
      push(4'd3, 4'd3); push(4'd2, 4'd2); push(4'd1, 4'd1);
      while (dones < k + 2 && !RESET) begin
         tick();
         if (dones >= k + 2) break;
      end
      k = 0;
      while (!bus.mul_start && k < 200) begin tick(); k++; end
      chk("rst_mid_start_seen", {31'd0, bus.mul_start}, 32'd1);
      tick();
      tick();
      RESET = 1'b1;
      tick();
      chk_reset("rst_mid");
      RESET = 1'b0;
      tick();
      repeat (4) push(4'd2, 4'd3);
      wait_sums(6, "fresh_timeout");

      // Done held high across the next start.
      stretch = 1'b1;
      push(4'd4, 4'd9); push(4'd1, 4'd1); push(4'd15, 4'd15); push(4'd0, 4'd7);
      push(4'd1, 4'd2); push(4'd3, 4'd4); push(4'd5, 4'd6); push(4'd7, 4'd8);
      wait_sums(8, "stretch_timeout");
      stretch = 1'b0;
      repeat (10) tick();

      chk("sum_q_drained", sum_q.size(), 32'd0);
      chk("pair_q_drained", pair_q.size(), 32'd0);
      chk("total_starts", starts, 32'd35);
      chk("total_sums", sums_seen, 32'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
